// File: rtl/regs_wr_arbiter_if.sv
// Register-file write port bundle: two requesting ports in, one registered
// register-file write out.
interface regs_wr_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [4:0]  reg_Wt_addr;
    logic [31:0] wdata;
    logic        we;
    logic        busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  reg_Wt_addr, wdata, we, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output reg_Wt_addr, wdata, we, busy
    );
endinterface

// File: rtl/regs_wr_arbiter.sv
// Two-port register-file write arbiter with one holding entry per port,
// fixed priority with starvation relief or round-robin, and a registered write port.
module regs_wr_arbiter #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    regs_wr_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]  ent_valid_r;
    logic [4:0]  ent_addr_r [2];
    logic [31:0] ent_data_r [2];
    logic [3:0]  starve_r;
    logic        last_grant_r;
    logic        we_r;
    logic [4:0]  wr_addr_r;
    logic [31:0] wr_data_r;

    logic [1:0]  req_valid_s;
    logic [4:0]  req_addr_s [2];
    logic [31:0] req_data_s [2];
    logic [1:0]  ready_s;
    logic [1:0]  load_s;
    logic [1:0]  grant_s;
    logic [4:0]  gnt_addr_s;
    logic [31:0] gnt_data_s;
    logic        issue_s;
    logic [3:0]  starve_nxt_s;
    logic        last_grant_nxt_s;

    assign req_valid_s   = {bus.req1_valid, bus.req0_valid};
    assign req_addr_s[0] = bus.req0_addr;
    assign req_addr_s[1] = bus.req1_addr;
    assign req_data_s[0] = bus.req0_data;
    assign req_data_s[1] = bus.req1_data;

    // A slot frees up in the same cycle it is granted, so a port can refill with no bubble.
    assign ready_s        = {2{rst}} & (~ent_valid_r | grant_s);
    assign load_s         = req_valid_s & ready_s;
    assign bus.req0_ready = ready_s[0];
    assign bus.req1_ready = ready_s[1];

    // Grant selection: lone entry always wins, contention resolved by priority mode.
    always_comb begin
        grant_s = 2'b00;
        case (ent_valid_r)
            2'b01: grant_s = 2'b01;
            2'b10: grant_s = 2'b10;
            2'b11: begin
                if (PRIO_MODE == 0) begin
                    if (starve_r == STARVE_MAX) begin
                        grant_s = 2'b10;
                    end else begin
                        grant_s = 2'b01;
                    end
                end else begin
                    if (last_grant_r) begin
                        grant_s = 2'b01;
                    end else begin
                        grant_s = 2'b10;
                    end
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    // Granted entry datapath; r0 targets consume the slot but never pulse we.
    always_comb begin
        gnt_addr_s = ent_addr_r[0];
        gnt_data_s = ent_data_r[0];
        if (grant_s[1]) begin
            gnt_addr_s = ent_addr_r[1];
            gnt_data_s = ent_data_r[1];
        end else begin
            gnt_addr_s = ent_addr_r[0];
            gnt_data_s = ent_data_r[0];
        end
        issue_s = (grant_s != 2'b00) && (gnt_addr_s != 5'd0);
    end

    // Starvation counter and round-robin pointer next-state.
    always_comb begin
        starve_nxt_s     = starve_r;
        last_grant_nxt_s = last_grant_r;
        if (grant_s[1]) begin
            starve_nxt_s = 4'd0;
        end else if (ent_valid_r[1] && grant_s[0] && (starve_r != STARVE_MAX)) begin
            starve_nxt_s = starve_r + 4'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
        if (grant_s != 2'b00) begin
            last_grant_nxt_s = grant_s[1];
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
    end

    // Holding entries: a new load takes precedence over clearing the granted slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                ent_addr_r[i] <= 5'd0;
                ent_data_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load_s[i]) begin
                    ent_valid_r[i] <= 1'b1;
                    ent_addr_r[i]  <= req_addr_s[i];
                    ent_data_r[i]  <= req_data_s[i];
                end else if (grant_s[i]) begin
                    ent_valid_r[i] <= 1'b0;
                end else begin
                    ent_valid_r[i] <= ent_valid_r[i];
                end
            end
        end
    end

    // Arbitration state; pointer resets to "port 1 last" so port 0 is favoured first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_r     <= 4'd0;
            last_grant_r <= 1'b1;
        end else begin
            starve_r     <= starve_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Registered write port; address/data hold whenever no write issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r      <= 1'b0;
            wr_addr_r <= 5'd0;
            wr_data_r <= 32'd0;
        end else begin
            we_r <= issue_s;
            if (issue_s) begin
                wr_addr_r <= gnt_addr_s;
                wr_data_r <= gnt_data_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign bus.we          = we_r;
    assign bus.reg_Wt_addr = wr_addr_r;
    assign bus.wdata       = wr_data_r;
    assign bus.busy        = (|ent_valid_r) | we_r;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed bench for regs_wr_arbiter: three instances (fixed/limit 4, round-robin,
// fixed/limit 1) share one stimulus; outputs are compared with hand-computed values.
module tb_regs_wr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        d_v0, d_v1;
    logic [4:0]  d_a0, d_a1;
    logic [31:0] d_d0, d_d1;

    int n_tests = 0;
    int n_fail  = 0;

    regs_wr_arbiter_if bus0 ();
    regs_wr_arbiter_if bus1 ();
    regs_wr_arbiter_if bus2 ();

    assign bus0.req0_valid = d_v0; assign bus0.req0_addr = d_a0; assign bus0.req0_data = d_d0;
    assign bus0.req1_valid = d_v1; assign bus0.req1_addr = d_a1; assign bus0.req1_data = d_d1;
    assign bus1.req0_valid = d_v0; assign bus1.req0_addr = d_a0; assign bus1.req0_data = d_d0;
    assign bus1.req1_valid = d_v1; assign bus1.req1_addr = d_a1; assign bus1.req1_data = d_d1;
    assign bus2.req0_valid = d_v0; assign bus2.req0_addr = d_a0; assign bus2.req0_data = d_d0;
    assign bus2.req1_valid = d_v1; assign bus2.req1_addr = d_a1; assign bus2.req1_data = d_d1;

    regs_wr_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4)) u_fix  (.clk(clk), .rst(rst), .bus(bus0));
    regs_wr_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(4)) u_rr   (.clk(clk), .rst(rst), .bus(bus1));
    regs_wr_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(1)) u_lim1 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0]  o_we, o_busy, o_rdy0, o_rdy1;
    logic [4:0]  o_addr [3];
    logic [31:0] o_data [3];

    assign o_we   = {bus2.we, bus1.we, bus0.we};
    assign o_busy = {bus2.busy, bus1.busy, bus0.busy};
    assign o_rdy0 = {bus2.req0_ready, bus1.req0_ready, bus0.req0_ready};
    assign o_rdy1 = {bus2.req1_ready, bus1.req1_ready, bus0.req1_ready};
    assign o_addr[0] = bus0.reg_Wt_addr; assign o_data[0] = bus0.wdata;
    assign o_addr[1] = bus1.reg_Wt_addr; assign o_data[1] = bus1.wdata;
    assign o_addr[2] = bus2.reg_Wt_addr; assign o_data[2] = bus2.wdata;

    // Grant pattern under continuous contention, bit g = 1 means port 1 took grant g.
    logic [9:0] pat [3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] dd0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] dd1);
        d_v0 = v0; d_a0 = a0; d_d0 = dd0;
        d_v1 = v1; d_a1 = a1; d_d1 = dd1;
    endtask

    task automatic check_outs(input string tag, input logic e_we, input logic [4:0] e_addr,
                              input logic [31:0] e_data, input logic e_busy);
        for (int n = 0; n < 3; n++) begin
            check_val($sformatf("%s.we[%0d]", tag, n), {31'd0, o_we[n]}, {31'd0, e_we});
            check_val($sformatf("%s.addr[%0d]", tag, n), {27'd0, o_addr[n]}, {27'd0, e_addr});
            check_val($sformatf("%s.wdata[%0d]", tag, n), o_data[n], e_data);
            check_val($sformatf("%s.busy[%0d]", tag, n), {31'd0, o_busy[n]}, {31'd0, e_busy});
        end
    endtask

    task automatic check_rdy(input string tag, input logic e0, input logic e1);
        for (int n = 0; n < 3; n++) begin
            check_val($sformatf("%s.rdy0[%0d]", tag, n), {31'd0, o_rdy0[n]}, {31'd0, e0});
            check_val($sformatf("%s.rdy1[%0d]", tag, n), {31'd0, o_rdy1[n]}, {31'd0, e1});
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        drive(1'b1, 5'd4, 32'h0000_0004, 1'b1, 5'd6, 32'h0000_0006);
        repeat (2) @(posedge clk);
        #1;
        check_outs(tag, 1'b0, 5'd0, 32'd0, 1'b0);
        check_rdy(tag, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pat[0] = 10'b10_0001_0000;
        pat[1] = 10'b10_1010_1010;
        pat[2] = 10'b10_1010_1010;
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_reset("reset");

        // Single write: handshake on first edge after release, write visible after the next.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        tick;
        check_outs("single.e1", 1'b0, 5'd0, 32'd0, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick;
        check_outs("single.e2", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1);
        tick;
        check_outs("single.e3", 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0);

        // Port 1 write to r9, then an r0 write that is consumed silently.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA5A5_A5A5);
        tick;
        check_rdy("r0.load", 1'b1, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234);
        tick;
        check_outs("r0.w9", 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick;
        check_outs("r0.drop", 1'b0, 5'd9, 32'hA5A5_A5A5, 1'b0);
        check_rdy("r0.drop", 1'b1, 1'b1);
        tick;
        check_outs("r0.after", 1'b0, 5'd9, 32'hA5A5_A5A5, 1'b0);

        // Same address on both ports: two writes, port 0 first in every instance.
        drive(1'b1, 5'd7, 32'h1111_0000, 1'b1, 5'd7, 32'h2222_0000);
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick;
        check_outs("same.w1", 1'b1, 5'd7, 32'h1111_0000, 1'b1);
        tick;
        check_outs("same.w2", 1'b1, 5'd7, 32'h2222_0000, 1'b1);
        tick;
        check_outs("same.idle", 1'b0, 5'd7, 32'h2222_0000, 1'b0);

        // Back-to-back stream on port 0, addrs 1..8.
        for (int t = 1; t <= 9; t++) begin
            if (t <= 8) begin
                drive(1'b1, 5'(t), 32'hC0DE_0000 | 32'(t), 1'b0, 5'd0, 32'd0);
                #1;
                for (int n = 0; n < 3; n++)
                    check_val($sformatf("b2b.rdy0[%0d]@%0d", n, t), {31'd0, o_rdy0[n]}, 32'd1);
            end else begin
                drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            end
            tick;
            if (t >= 2)
                check_outs($sformatf("b2b.w%0d", t - 1), 1'b1, 5'(t - 1),
                           32'hC0DE_0000 | 32'(t - 1), 1'b1);
        end
        tick;
        check_outs("b2b.end", 1'b0, 5'd8, 32'hC0DE_0008, 1'b0);

        // Continuous contention from reset: per-instance grant order.
        do_reset("reset2");
        drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd17, 32'h1717_1717);
        tick;
        for (int g = 0; g < 10; g++) begin
            tick;
            for (int n = 0; n < 3; n++) begin
                check_val($sformatf("cont.we[%0d]g%0d", n, g), {31'd0, o_we[n]}, 32'd1);
                check_val($sformatf("cont.addr[%0d]g%0d", n, g), {27'd0, o_addr[n]},
                          pat[n][g] ? 32'd17 : 32'd3);
                check_val($sformatf("cont.wdata[%0d]g%0d", n, g), o_data[n],
                          pat[n][g] ? 32'h1717_1717 : 32'h3333_3333);
            end
        end

        // Reset mid-stream: we and busy drop asynchronously, nothing stale after release.
        do_reset("reset3");
        drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd17, 32'h1717_1717);
        tick;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick;
        check_outs("mid.pre", 1'b1, 5'd3, 32'h3333_3333, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("mid.async", 1'b0, 5'd0, 32'd0, 1'b0);
        check_rdy("mid.async", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        check_outs("mid.rel1", 1'b0, 5'd0, 32'd0, 1'b0);
        tick;
        check_outs("mid.rel2", 1'b0, 5'd0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regs_wr_arbiter.md
REGS_WR_ARBITER -- requirements
Module: regs_wr_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_MODE, default 0, meaning 0 = fixed priority (port 0 high) and 1 = round-robin.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive port-1 losses (PRIO_MODE=0 only) after which port 1 is forced to win once; range 1..15.
REQ-003 The block SHALL have ports:
  clk  in  1  single clock, all state updates on rising edge
  rst  in  1  asynchronous, active-low reset (0 = reset asserted)
  req0_valid  in  1  port 0 (writeback) write request
  req0_addr  in  5  port 0 destination register
  req0_data  in  32  port 0 write data
  req0_ready  out  1  port 0 can accept
  req1_valid  in  1  port 1 (auxiliary unit) write request
  req1_addr  in  5  port 1 destination register
  req1_data  in  32  port 1 write data
  req1_ready  out  1  port 1 can accept
  reg_Wt_addr  out  5  register-file write address, registered
  wdata  out  32  register-file write data, registered
  we  out  1  register-file write enable, registered, one-cycle pulse per write
  busy  out  1  any holding entry valid or we high

Function
REQ-004 Each port SHALL own one holding entry (valid, addr, data); a handshake occurs on a rising edge where reqN_valid=1 and reqN_ready=1 and loads the entry.
REQ-005 reqN_ready SHALL equal (entry N empty) OR (entry N granted in the current cycle), and SHALL be 0 while rst=0.
REQ-006 Each cycle the arbiter SHALL grant at most one valid entry; the granted entry is cleared and its addr/data loaded into reg_Wt_addr/wdata with we=1 on the same edge.
REQ-007 Latency SHALL be exactly: handshake at edge k -> we=1 for the cycle after edge k+1 when uncontested; combined throughput SHALL be one write per cycle.
REQ-008 we SHALL be 0 in any cycle following an edge with no grant; reg_Wt_addr/wdata SHALL hold their last values when we=0.
REQ-009 An entry with addr=0 SHALL be accepted and cleared at its grant without asserting we (r0 writes dropped, slot consumed).
REQ-010 PRIO_MODE=0: port 0 wins when both valid, except when starve counter equals STARVE_LIMIT, in which case port 1 wins and the counter clears.
REQ-011 Starve counter (4 bits) SHALL increment when port 1 valid and loses, clear when port 1 granted, hold otherwise; it SHALL saturate at STARVE_LIMIT.
REQ-012 PRIO_MODE=1: a last-grant pointer SHALL select the port not granted most recently when both valid; pointer updates only on a grant.
REQ-013 A single valid entry SHALL be granted the same cycle regardless of priority state.
REQ-014 Both entries targeting the same address SHALL be issued as two separate writes in grant order; no merging or cancellation.
REQ-015 A new handshake on port N in the same cycle its entry is granted SHALL load the new request while the old one issues (no bubble, no loss).
REQ-016 Outputs SHALL be stable from rising edge through the following falling edge so a negedge-writing register file captures them.

Reset
REQ-017 While rst=0: entries invalid, we=0, reg_Wt_addr=0, wdata=0, busy=0, readies 0, starve counter 0, round-robin pointer favouring port 0.
REQ-018 Reset assertion mid-operation SHALL discard pending entries immediately and asynchronously drop we; no write SHALL issue on the first edge after release.

Verification
REQ-019 Single write: port 0 valid addr=5 data=0xDEADBEEF at edge 1 -> we=1, reg_Wt_addr=5, wdata=0xDEADBEEF after edge 2 only.
REQ-020 Contention, PRIO_MODE=0, STARVE_LIMIT=4: both ports valid continuously -> port 0 wins 4 times, port 1 wins 5th grant, pattern repeats.
REQ-021 Contention, PRIO_MODE=1: both valid continuously -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-022 r0 drop: port 1 addr=0 data=0x1234 -> entry consumed, we stays 0, req1_ready returns 1 next cycle.
REQ-023 Back-to-back: port 0 valid every cycle addrs 1..8 -> we=1 for 8 consecutive cycles, addrs in order, req0_ready never 0.
REQ-024 Reset mid-stream: rst=0 while both entries valid -> we=0 immediately, busy=0; after release no stale write appears.
